// File: rtl/write_access_arbiter.sv
// Round-robin write arbiter that checks each captured request against a
// per-requester address window before forwarding it to memory or raising an alert.
module write_access_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  input  logic                        cfg_we,
  input  logic [ID_W-1:0]             cfg_id,
  input  logic                        cfg_en,
  input  logic [ADDR_W-1:0]           cfg_lo,
  input  logic [ADDR_W-1:0]           cfg_hi,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  output logic                        alert_valid,
  output logic [ID_W-1:0]             alert_id,
  output logic [ADDR_W-1:0]           alert_addr,
  output logic [DATA_W-1:0]           alert_data,
  input  logic                        alert_ack,
  output logic [7:0]                  viol_count,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, CHECK, WRITE, ALERT} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, last_id_q, win_id;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [7:0]          viol_q;
  logic                win_found, pass;
  logic                en_q [NUM_REQ];
  logic [ADDR_W-1:0]   lo_q [NUM_REQ];
  logic [ADDR_W-1:0]   hi_q [NUM_REQ];

  // Scan starts just after the last served ID so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[ID_W'((32'(last_id_q) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_id    = ID_W'((32'(last_id_q) + k) % NUM_REQ);
      end
    end
  end

  // Table registers are read here, so a same-cycle cfg write lands after this check.
  always_comb pass = en_q[id_q] && (lo_q[id_q] <= addr_q) && (addr_q <= hi_q[id_q]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = CHECK;
      CHECK:   state_d = pass ? WRITE : ALERT;
      WRITE:   if (mem_ready) state_d = IDLE;
      ALERT:   if (alert_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt         = '0;
    if (state_q == CHECK) gnt[id_q] = 1'b1;
    mem_we      = (state_q == WRITE);
    mem_addr    = mem_we ? addr_q : '0;
    mem_wdata   = mem_we ? data_q : '0;
    alert_valid = (state_q == ALERT);
    alert_id    = alert_valid ? id_q   : '0;
    alert_addr  = alert_valid ? addr_q : '0;
    alert_data  = alert_valid ? data_q : '0;
    viol_count  = viol_q;
    busy        = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      last_id_q <= '1;
      viol_q    <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        en_q[i] <= 1'b0;
        lo_q[i] <= '0;
        hi_q[i] <= '1;
      end
    end else begin
      if (state_q == IDLE && win_found) begin
        id_q   <= win_id;
        addr_q <= req_addr[win_id*ADDR_W +: ADDR_W];
        data_q <= req_data[win_id*DATA_W +: DATA_W];
      end
      if (state_q == CHECK && !pass && viol_q != '1) viol_q <= viol_q + 8'd1;
      if ((state_q == WRITE && mem_ready) || (state_q == ALERT && alert_ack))
        last_id_q <= id_q;
      if (cfg_we) begin
        en_q[cfg_id] <= cfg_en;
        lo_q[cfg_id] <= cfg_lo;
        hi_q[cfg_id] <= cfg_hi;
      end
    end
  end

endmodule
